// File: rtl/fc_sample_pkg.sv
// fc_sample_pkg: register map and bit positions shared by the frequency-counter sample peripheral.
package fc_sample_pkg;

    typedef enum logic [7:0] {
        OFS_CTRL        = 8'h00,
        OFS_HEAD_REF    = 8'h04,
        OFS_HEAD_SIG    = 8'h08,
        OFS_HEAD_SIGSYS = 8'h0C,
        OFS_STATUS      = 8'h10,
        OFS_POP         = 8'h14,
        OFS_GPIO_IN     = 8'h18
    } reg_ofs_e;

    localparam int CTRL_IRQEN     = 16;
    localparam int CTRL_OVWR      = 17;
    localparam int STAT_EMPTY     = 8;
    localparam int STAT_FULL      = 9;
    localparam int STAT_OVF       = 10;
    localparam int STAT_EPOCH_LSB = 16;

endpackage

// File: rtl/fc_sample_fifo.sv
// fc_sample_fifo: sample FIFO with drop-newest or drop-oldest behaviour when full.
module fc_sample_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  logic          overwrite,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop_ok, drop_old, wr_en;

    assign count = cnt_q;
    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
    assign head  = empty ? '0 : mem_q[rd_q];

    // A pop frees a slot first, so push+pop on a full FIFO never overflows.
    always_comb begin
        pop_ok   = pop && !empty;
        drop_old = push && full && !pop_ok && overwrite;
        wr_en    = push && (!full || pop_ok || overwrite);
        ovf      = push && full && !pop_ok;
        mem_d    = mem_q;
        if (wr_en) mem_d[wr_q] = din;
        wr_d     = wr_q + PW'(wr_en);
        rd_d     = rd_q + PW'(pop_ok || drop_old);
        cnt_d    = cnt_q + CW'(wr_en) - CW'(pop_ok || drop_old);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/fc_sample_regs.sv
// fc_sample_regs: iomem peripheral exposing buffered frequency-counter samples, GPIO and irq.
module fc_sample_regs
    import fc_sample_pkg::*;
#(
    parameter int SIG_BITS = 32,
    parameter int SYS_BITS = 32,
    parameter int EPOCH_BITS = 8,
    parameter int DEPTH = 4,
    parameter int GPIO_BITS = 6,
    parameter logic [7:0] BASE = 8'h03
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    input  logic [SYS_BITS-1:0]  in_ref_sys_cnt,
    input  logic [SIG_BITS-1:0]  in_sig_cnt,
    input  logic [SYS_BITS-1:0]  in_sig_sys_cnt,
    input  logic                 iomem_valid,
    output logic                 iomem_ready,
    input  logic [3:0]           iomem_wstrb,
    input  logic [31:0]          iomem_addr,
    input  logic [31:0]          iomem_wdata,
    output logic [31:0]          iomem_rdata,
    output logic [GPIO_BITS-1:0] gpio_out,
    input  logic                 gpio_in,
    output logic                 irq
);
    localparam int W  = EPOCH_BITS + 2 * SYS_BITS + SIG_BITS;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [31:0] CTRL_MASK = ((32'd1 << GPIO_BITS) - 32'd1) | (32'd3 << CTRL_IRQEN);

    logic [EPOCH_BITS-1:0] epoch_q, epoch_d, h_epoch;
    logic [31:0]           ctrl_q, ctrl_d, rdata_q, rdata_d, rd_val, status;
    logic                  ready_q, ready_d, irq_q, irq_d, ovf_q, ovf_d;
    logic [1:0]            sync_q, sync_d;
    logic                  hit, wr, fifo_pop, fifo_ovf, fifo_full, fifo_empty;
    logic [7:0]            ofs;
    logic [W-1:0]          head;
    logic [CW-1:0]         count;
    logic [SYS_BITS-1:0]   h_ref, h_sigsys;
    logic [SIG_BITS-1:0]   h_sig;
    logic                  unused_bits;

    assign {h_epoch, h_ref, h_sig, h_sigsys} = head;
    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq         = irq_q;
    assign gpio_out    = ctrl_q[GPIO_BITS-1:0];
    assign unused_bits = ^{iomem_addr[23:8], iomem_wstrb[3], iomem_wdata[31:24], iomem_wdata[15:11], iomem_wdata[9:8]};

    fc_sample_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (in_valid),
        .pop       (fifo_pop),
        .overwrite (ctrl_q[CTRL_OVWR]),
        .din       ({epoch_q, in_ref_sys_cnt, in_sig_cnt, in_sig_sys_cnt}),
        .head      (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .ovf       (fifo_ovf)
    );

    always_comb begin
        ofs      = iomem_addr[7:0];
        hit      = iomem_valid && !ready_q && iomem_addr[31:24] == BASE;
        wr       = hit && |iomem_wstrb;
        fifo_pop = wr && ofs == OFS_POP;
        status   = '0;
        status[CW-1:0] = count;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_FULL]  = fifo_full;
        status[STAT_OVF]   = ovf_q;
        status[STAT_EPOCH_LSB +: EPOCH_BITS] = h_epoch;
        case (ofs)
            OFS_CTRL:        rd_val = ctrl_q;
            OFS_HEAD_REF:    rd_val = 32'(h_ref);
            OFS_HEAD_SIG:    rd_val = 32'(h_sig);
            OFS_HEAD_SIGSYS: rd_val = 32'(h_sigsys);
            OFS_STATUS:      rd_val = status;
            OFS_POP:         rd_val = 32'(epoch_q);
            OFS_GPIO_IN:     rd_val = {31'b0, sync_q[1]};
            default:         rd_val = '0;
        endcase
        ctrl_d = ctrl_q;
        if (wr && ofs == OFS_CTRL && iomem_wstrb[0]) ctrl_d[7:0] = iomem_wdata[7:0];
        if (wr && ofs == OFS_CTRL && iomem_wstrb[2]) ctrl_d[23:16] = iomem_wdata[23:16];
        ctrl_d  = ctrl_d & CTRL_MASK;
        // A same-cycle overflow beats a firmware clear so no drop goes unreported.
        ovf_d   = fifo_ovf || (ovf_q && !(wr && ofs == OFS_STATUS && iomem_wstrb[1] && iomem_wdata[STAT_OVF]));
        epoch_d = epoch_q + EPOCH_BITS'(in_valid);
        sync_d  = {sync_q[0], gpio_in};
        ready_d = hit;
        rdata_d = hit ? rd_val : '0;
        irq_d   = ctrl_q[CTRL_IRQEN] && count != '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            epoch_q <= '0;
            ctrl_q  <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
            sync_q  <= '0;
        end else begin
            epoch_q <= epoch_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            irq_q   <= irq_d;
            ovf_q   <= ovf_d;
            sync_q  <= sync_d;
        end
    end
endmodule

// File: tb/tb_fc_sample_regs.sv
// tb_fc_sample_regs: randomized bench for fc_sample_regs against a queue-based reference model.
module tb_fc_sample_regs;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, iomem_valid = 1'b0, gpio_in = 1'b0;
    logic [31:0] in_ref = '0, in_sig = '0, in_ss = '0, iomem_addr = '0, iomem_wdata = '0;
    logic [3:0]  iomem_wstrb = '0;
    logic        iomem_ready, irq;
    logic [31:0] iomem_rdata;
    logic [5:0]  gpio_out;

    always #5 clk = ~clk;

    fc_sample_regs dut (
        .clk            (clk),
        .resetn         (resetn),
        .in_valid       (in_valid),
        .in_ref_sys_cnt (in_ref),
        .in_sig_cnt     (in_sig),
        .in_sig_sys_cnt (in_ss),
        .iomem_valid    (iomem_valid),
        .iomem_ready    (iomem_ready),
        .iomem_wstrb    (iomem_wstrb),
        .iomem_addr     (iomem_addr),
        .iomem_wdata    (iomem_wdata),
        .iomem_rdata    (iomem_rdata),
        .gpio_out       (gpio_out),
        .gpio_in        (gpio_in),
        .irq            (irq)
    );

    int checks = 0, errors = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] r, s, ss;
        int unsigned tag;
    } smp_t;

    smp_t        q[$];
    int unsigned epoch;
    bit          ovf, gin;
    logic [31:0] ctrl;

    function automatic void model_reset();
        q.delete();
        epoch = 0;
        ovf   = 0;
        ctrl  = '0;
    endfunction

    function automatic logic [31:0] exp_rd(logic [7:0] o);
        bit e = q.size() == 0;
        case (o)
            8'h00: return ctrl;
            8'h04: return e ? 32'd0 : q[0].r;
            8'h08: return e ? 32'd0 : q[0].s;
            8'h0C: return e ? 32'd0 : q[0].ss;
            8'h10: return 32'(q.size()) | (32'(e) << 8) | (32'(q.size() == DEPTH) << 9)
                          | (32'(ovf) << 10) | ((e ? 32'd0 : q[0].tag) << 16);
            8'h14: return epoch;
            8'h18: return 32'(gin);
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick(bit iv, logic [31:0] r, logic [31:0] s, logic [31:0] ss,
                        bit bv, logic [31:0] addr, logic [3:0] ws, logic [31:0] wd);
        bit          hit  = bv && addr[31:24] == 8'h03;
        logic [7:0]  o    = addr[7:0];
        logic [31:0] er   = hit ? exp_rd(o) : 32'd0;
        bit          eirq = ctrl[16] && q.size() != 0;
        smp_t        smp;
        in_valid = iv; in_ref = r; in_sig = s; in_ss = ss;
        iomem_valid = bv; iomem_addr = addr; iomem_wstrb = ws; iomem_wdata = wd;
        @(posedge clk);
        #1;
        if (hit && o == 8'h10 && ws[1] && wd[10]) ovf = 0;
        if (hit && o == 8'h14 && ws != 0 && q.size() > 0) void'(q.pop_front());
        if (iv) begin
            smp = '{r: r, s: s, ss: ss, tag: epoch};
            if (q.size() < DEPTH) q.push_back(smp);
            else begin
                ovf = 1;
                if (ctrl[17]) begin
                    void'(q.pop_front());
                    q.push_back(smp);
                end
            end
            epoch = (epoch + 1) % 256;
        end
        if (hit && o == 8'h00 && ws[0]) ctrl[7:0] = wd[7:0];
        if (hit && o == 8'h00 && ws[2]) ctrl[23:16] = wd[23:16];
        ctrl &= 32'h0003_003F;
        chk("ready", 32'(iomem_ready), 32'(hit));
        if (hit) chk($sformatf("rdata@%02h", o), iomem_rdata, er);
        chk("irq", 32'(irq), 32'(eirq));
        chk("gpio_out", 32'(gpio_out), ctrl & 32'h3F);
        in_valid = 0;
        iomem_valid = 0;
        if (bv) begin
            @(posedge clk);
            #1;
            chk("ready_drop", 32'(iomem_ready), 32'd0);
        end
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(logic [31:0] r);
        tick(1, r, $urandom, $urandom, 0, 0, 0, 0);
    endtask

    task automatic rd(logic [7:0] o);
        tick(0, 0, 0, 0, 1, {24'h03_0000, o}, 4'h0, 0);
    endtask

    task automatic wr(logic [7:0] o, logic [3:0] ws, logic [31:0] d);
        tick(0, 0, 0, 0, 1, {24'h03_0000, o}, ws, d);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) wr(8'h14, 4'hF, 0);
    endtask

    bit [7:0] ofs_t [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h40};

    initial begin
        model_reset();
        gin = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(iomem_ready), 0);
        chk("rst_rdata", iomem_rdata, 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_gpio", 32'(gpio_out), 0);
        resetn = 1;
        rd(8'h10);
        push(10); push(20); push(30);
        rd(8'h10); rd(8'h04);
        wr(8'h14, 4'hF, 0);
        rd(8'h04); rd(8'h10); rd(8'h08); rd(8'h0C);
        drain();
        for (int i = 1; i <= 6; i++) push(i);
        rd(8'h10); rd(8'h04); rd(8'h14);
        wr(8'h10, 4'h2, 32'h400);
        rd(8'h10);
        drain();
        wr(8'h00, 4'h4, 32'h2_0000);
        for (int i = 1; i <= 6; i++) push(i);
        rd(8'h04); rd(8'h10); rd(8'h00);
        wr(8'h10, 4'h2, 32'h400);
        wr(8'h00, 4'h4, 32'h0);
        tick(1, 32'h77, 1, 2, 1, 32'h0300_0014, 4'hF, 0);
        rd(8'h10);
        drain();
        rd(8'h10);
        wr(8'h00, 4'h5, 32'h1002A);
        idle();
        push(32'h55);
        idle(); idle();
        drain();
        idle(); idle();
        rd(8'h40);
        wr(8'h40, 4'hF, 32'hFFFF_FFFF);
        tick(0, 0, 0, 0, 1, 32'h0400_0000, 4'h0, 0);
        tick(0, 0, 0, 0, 1, 32'h0400_0000, 4'hF, 32'h3F);
        gpio_in = 1;
        repeat (3) idle();
        gin = 1;
        rd(8'h18);
        for (int i = 0; i < 400; i++) begin
            int unsigned k = $urandom % 10;
            logic [7:0] o = k >= 8 ? 8'h14 : ofs_t[k];
            logic [31:0] a = ($urandom % 10 == 0) ? {24'h04_0000, o} : {24'h03_0000, o};
            logic [3:0] ws = ($urandom % 2) ? 4'h0 : 4'($urandom);
            tick($urandom % 3 == 0, $urandom, $urandom, $urandom, $urandom % 3 != 0, a, ws, $urandom);
        end
        gpio_in = 0;
        repeat (3) idle();
        gin = 0;
        rd(8'h18);
        iomem_valid = 1; iomem_addr = 32'h0300_0010; iomem_wstrb = 0;
        #2 resetn = 0;
        @(posedge clk);
        #1;
        chk("abort_ready", 32'(iomem_ready), 0);
        chk("abort_rdata", iomem_rdata, 0);
        chk("abort_irq", 32'(irq), 0);
        iomem_valid = 0;
        @(posedge clk);
        #1;
        resetn = 1;
        model_reset();
        rd(8'h10);
        rd(8'h14);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
